// File: rtl/gray_pkg.sv
// Shared helpers for Gray-coded FIFO pointers. The conversion functions work on
// a fixed 32-bit container, so callers zero-extend their input and truncate the result.
package gray_pkg;

  localparam int SIDE_WR = 0;
  localparam int SIDE_RD = 1;
  localparam int GW      = 32;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros from zero-extension leave the low bits unaffected.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_reg.sv
// Multi-flop synchroniser for a Gray-coded peer pointer; clears to zero on reset.
module gray_sync_reg #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* async_reg = "true" *) logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_fifo_side_status.sv
// One clock-domain side of a dual-clock FIFO: local pointer, Gray export,
// synchronised peer pointer and registered, conservative fill level/flags.
module gray_fifo_side_status
  import gray_pkg::*;
#(
  parameter int A_BITS      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0,
  parameter int HIGH_LEVEL  = (1 << A_BITS) - 2,
  parameter int LOW_LEVEL   = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Strobe,
  output logic              Accept,
  output logic [A_BITS-1:0] Ptr_Addr,
  output logic [A_BITS:0]   Ptr_Gray,
  input  logic [A_BITS:0]   Remote_Gray,
  output logic [A_BITS:0]   Level,
  output logic              Full,
  output logic              Empty,
  output logic              High,
  output logic              Low
);

  localparam int PW    = A_BITS + 1;
  localparam int DEPTH = 1 << A_BITS;

  if (A_BITS < 2) begin : g_chk_abits
    $error("gray_fifo_side_status: A_BITS must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("gray_fifo_side_status: SYNC_STAGES must be >= 2");
  end
  if (!(LOW_LEVEL < HIGH_LEVEL && HIGH_LEVEL <= DEPTH)) begin : g_chk_levels
    $error("gray_fifo_side_status: need LOW_LEVEL < HIGH_LEVEL <= DEPTH");
  end

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] remote_sync;
  logic [PW-1:0] remote_bin_q, remote_bin_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          high_q, high_d;
  logic          low_q, low_d;
  logic          blocked;
  logic          accept;

  gray_sync_reg #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (Clock),
    .rst (Reset),
    .d   (Remote_Gray),
    .q   (remote_sync)
  );

  // Level is taken from the post-accept pointer so a local accept shows up in
  // the very next Level update, never a cycle late.
  always_comb begin
    blocked      = (SIDE == SIDE_RD) ? empty_q : full_q;
    accept       = Strobe & ~Reset & ~blocked;
    bin_d        = accept ? bin_q + PW'(1) : bin_q;
    gray_d       = PW'(bin2gray(GW'(bin_d)));
    remote_bin_d = PW'(gray2bin(GW'(remote_sync)));
    level_d      = (SIDE == SIDE_RD) ? (remote_bin_q - bin_d) : (bin_d - remote_bin_q);
    full_d       = (level_d == PW'(DEPTH));
    empty_d      = (level_d == '0);
    high_d       = (level_d >= PW'(HIGH_LEVEL));
    low_d        = (level_d <= PW'(LOW_LEVEL));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bin_q        <= '0;
      gray_q       <= '0;
      remote_bin_q <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      high_q       <= 1'b0;
      low_q        <= 1'b1;
    end else begin
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      remote_bin_q <= remote_bin_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      high_q       <= high_d;
      low_q        <= low_d;
    end
  end

  assign Accept   = accept;
  assign Ptr_Addr = bin_q[A_BITS-1:0];
  assign Ptr_Gray = gray_q;
  assign Level    = level_q;
  assign Full     = full_q;
  assign Empty    = empty_q;
  assign High     = high_q;
  assign Low      = low_q;

endmodule

// File: tb/tb_gray_fifo_side_status.sv
// Directed bench: a write-side and a read-side instance (DEPTH=8) driven by
// hand-sequenced steps with hand-computed expectations.
module tb_gray_fifo_side_status;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb_wr, acc_wr, full_wr, empty_wr, high_wr, low_wr;
  logic [2:0] addr_wr;
  logic [3:0] gray_wr, rg_wr, lvl_wr;
  logic       stb_rd, acc_rd, full_rd, empty_rd, high_rd, low_rd;
  logic [2:0] addr_rd;
  logic [3:0] gray_rd, rg_rd, lvl_rd;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] gray_tbl [16];
  int r_loc, r_rem;

  always #5 clk = ~clk;

  gray_fifo_side_status #(.A_BITS(3), .SYNC_STAGES(2), .SIDE(0), .HIGH_LEVEL(6), .LOW_LEVEL(2)) dut_wr (
    .Clock(clk), .Reset(rst), .Strobe(stb_wr), .Accept(acc_wr), .Ptr_Addr(addr_wr),
    .Ptr_Gray(gray_wr), .Remote_Gray(rg_wr), .Level(lvl_wr),
    .Full(full_wr), .Empty(empty_wr), .High(high_wr), .Low(low_wr)
  );

  gray_fifo_side_status #(.A_BITS(3), .SYNC_STAGES(2), .SIDE(1), .HIGH_LEVEL(6), .LOW_LEVEL(2)) dut_rd (
    .Clock(clk), .Reset(rst), .Strobe(stb_rd), .Accept(acc_rd), .Ptr_Addr(addr_rd),
    .Ptr_Gray(gray_rd), .Remote_Gray(rg_rd), .Level(lvl_rd),
    .Full(full_rd), .Empty(empty_rd), .High(high_rd), .Low(low_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge following the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_side(input string tag, input bit rd, input int lvl);
    logic [3:0] l;
    logic f, e, h, lo;
    l  = rd ? lvl_rd   : lvl_wr;
    f  = rd ? full_rd  : full_wr;
    e  = rd ? empty_rd : empty_wr;
    h  = rd ? high_rd  : high_wr;
    lo = rd ? low_rd   : low_wr;
    check({tag, "_level"}, 32'(l), 32'(lvl));
    check({tag, "_full"},  32'(f), 32'(lvl == 8));
    check({tag, "_empty"}, 32'(e), 32'(lvl == 0));
    check({tag, "_high"},  32'(h), 32'(lvl >= 6));
    check({tag, "_low"},   32'(lo), 32'(lvl <= 2));
  endtask

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset held with strobes active: nothing may be accepted.
    rst = 1'b1; stb_wr = 1'b1; stb_rd = 1'b1; rg_wr = 4'b0000; rg_rd = 4'b0000;
    #2;
    check("rst_acc_wr", 32'(acc_wr), 32'd0);
    check("rst_acc_rd", 32'(acc_rd), 32'd0);
    check("rst_gray_wr", 32'(gray_wr), 32'd0);
    check("rst_gray_rd", 32'(gray_rd), 32'd0);
    check_side("rst_wr", 1'b0, 0);
    check_side("rst_rd", 1'b1, 0);
    tick(2);
    check("rst_hold_acc_wr", 32'(acc_wr), 32'd0);
    rst = 1'b0; stb_wr = 1'b0; stb_rd = 1'b0;
    tick(1);

    // Write side fills to 8; the ninth strobe is refused.
    for (int k = 1; k <= 9; k++) begin
      stb_wr = 1'b1;
      #1;
      check("fill_acc", 32'(acc_wr), 32'(k <= 8));
      tick(1);
      check_side("fill", 1'b0, (k <= 8) ? k : 8);
    end
    stb_wr = 1'b0;
    check("fill_gray", 32'(gray_wr), 32'b1100);
    check("fill_addr", 32'(addr_wr), 32'd0);

    // Peer read pointer jumps to 3 (Gray 0010): Level follows 4 edges later.
    rg_wr = 4'b0010;
    tick(3);
    check_side("wr_lat3", 1'b0, 8);
    tick(1);
    check_side("wr_lat4", 1'b0, 5);

    // Read side sees peer write pointer 5 (Gray 0111), then drains.
    rg_rd = 4'b0111;
    tick(3);
    check_side("rd_lat3", 1'b1, 0);
    tick(1);
    check_side("rd_lat4", 1'b1, 5);
    for (int k = 1; k <= 6; k++) begin
      stb_rd = 1'b1;
      #1;
      check("drain_acc", 32'(acc_rd), 32'(k <= 5));
      tick(1);
      check_side("drain", 1'b1, (k <= 5) ? 5 - k : 0);
    end
    stb_rd = 1'b0;
    check("drain_gray", 32'(gray_rd), 32'b0111);

    // Pointer wrap on the read side: peer advances one at a time, 20 steps.
    r_loc = 5; r_rem = 5;
    for (int s = 0; s < 20; s++) begin
      r_rem = (r_rem + 1) % 16;
      rg_rd = gray_tbl[r_rem];
      tick(3);
      check("wrap_pre_level", 32'(lvl_rd), 32'd0);
      tick(1);
      check("wrap_level1", 32'(lvl_rd), 32'd1);
      stb_rd = 1'b1;
      #1;
      check("wrap_acc", 32'(acc_rd), 32'd1);
      tick(1);
      stb_rd = 1'b0;
      r_loc = (r_loc + 1) % 16;
      check_side("wrap_level0", 1'b1, 0);
      check("wrap_gray", 32'(gray_rd), 32'(gray_tbl[r_loc]));
      check("wrap_addr", 32'(addr_rd), 32'(r_loc % 8));
    end

    // Write side to Level 4, then a local accept lands on the same edge as
    // the peer increment reaching Level.
    rg_wr = 4'b0110;
    tick(4);
    check_side("wr_lvl4", 1'b0, 4);
    rg_wr = 4'b0111;
    tick(3);
    check_side("simul_pre", 1'b0, 4);
    stb_wr = 1'b1;
    #1;
    check("simul_acc", 32'(acc_wr), 32'd1);
    tick(1);
    stb_wr = 1'b0;
    check_side("simul_post", 1'b0, 4);
    check("simul_gray", 32'(gray_wr), 32'b1101);
    check("simul_addr", 32'(addr_wr), 32'd1);

    // Reset asserted between clock edges during traffic takes effect at once.
    stb_wr = 1'b1; stb_rd = 1'b1;
    #1;
    check("traffic_acc_wr", 32'(acc_wr), 32'd1);
    check("traffic_acc_rd", 32'(acc_rd), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_acc_wr", 32'(acc_wr), 32'd0);
    check("mid_rst_gray_wr", 32'(gray_wr), 32'd0);
    check("mid_rst_addr_wr", 32'(addr_wr), 32'd0);
    check("mid_rst_gray_rd", 32'(gray_rd), 32'd0);
    check_side("mid_rst_wr", 1'b0, 0);
    check_side("mid_rst_rd", 1'b1, 0);
    tick(2);
    stb_wr = 1'b0; stb_rd = 1'b0;
    rst = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
